// File: rtl/vga_tile_renderer_if.sv
// Row-write port of the tile renderer.
//   master: game logic side. It drives wr_valid, wr_row and wr_data.
//   slave : renderer side. It drives wr_ready.
// A transfer happens on every clock edge where wr_valid and wr_ready are both high.
interface vga_tile_renderer_if #(
    parameter int GRID_COLS = 8,
    parameter int RW        = 3
);
    logic                   wr_valid;
    logic                   wr_ready;
    logic [RW-1:0]          wr_row;
    logic [GRID_COLS*8-1:0] wr_data;

    modport master (output wr_valid, wr_row, wr_data, input wr_ready);
    modport slave  (input wr_valid, wr_row, wr_data, output wr_ready);
endinterface

// File: rtl/vga_tile_renderer.sv
// VGA tile renderer.
// It generates the raster timing and shows a GRID_COLS x GRID_ROWS array of tiles.
// Each tile holds one RGB332 colour.
// The default raster is 640x480@60. The H_*/V_* parameters let a reduced raster be built.
// Ports:
//   board_clk, reset    clock; asynchronous active-high reset
//   wr (slave)          row write port: wr_valid/wr_ready/wr_row/wr_data.
//                       Tile c of the row = wr_data[8c+7:8c], packed as {R[2:0],G[2:0],B[1:0]}.
//   vga_h_sync/v_sync   active-low syncs, aligned with rgb
//   vga_r/g/b           colour outputs; 0 outside the tile grid and in blanking
//   in_vblank           high while the line counter is in vertical blanking
//   frame_start         one-clock pulse on the pixel tick where x=0, y=0
// With VSYNC_WRITE=1 a row write is parked in a one-entry buffer.
// It is committed during vblank, so a frame never shows a half-updated row.
module vga_tile_renderer #(
    parameter int CLK_DIV_LOG2 = 2,
    parameter int GRID_COLS    = 8,
    parameter int GRID_ROWS    = 8,
    parameter int TILE_W       = 80,
    parameter int TILE_H       = 60,
    parameter bit VSYNC_WRITE  = 1'b1,
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33
) (
    input  logic               board_clk,
    input  logic               reset,
    vga_tile_renderer_if.slave wr,
    output logic               vga_h_sync,
    output logic               vga_v_sync,
    output logic [2:0]         vga_r,
    output logic [2:0]         vga_g,
    output logic [1:0]         vga_b,
    output logic               in_vblank,
    output logic               frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);
    localparam int RW      = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
    localparam int CW      = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
    localparam int DW      = (CLK_DIV_LOG2 > 0) ? CLK_DIV_LOG2 : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'((1 << CLK_DIV_LOG2) - 1);

    // ---------------- raster timing ----------------
    logic [DW-1:0] div;
    logic          pe;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          x_last;
    logic          y_last;
    logic [YW-1:0] y_nxt;

    // With CLK_DIV_LOG2=0, DIV_MAX is 0 and the divider sits at 0, so pe is always high.
    assign pe     = (div == DIV_MAX);
    assign x_last = (int'(x) == H_TOTAL - 1);
    assign y_last = (int'(y) == V_TOTAL - 1);
    assign y_nxt  = x_last ? (y_last ? '0 : y + YW'(1)) : y;

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            div         <= '0;
            x           <= '0;
            y           <= '0;
            in_vblank   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            div         <= pe ? '0 : div + DW'(1);
            if (pe) begin
                frame_start <= (x == '0) && (y == '0);
                x           <= x_last ? '0 : x + XW'(1);
                y           <= y_nxt;
                in_vblank   <= (int'(y_nxt) >= V_ACTIVE);
            end
        end
    end

    // ---------------- tile store and write port ----------------
    logic [7:0]             tiles [GRID_ROWS][GRID_COLS];
    logic                   pend_valid;
    logic [RW-1:0]          pend_row;
    logic [GRID_COLS*8-1:0] pend_data;
    logic                   xfer;
    logic                   commit_en;
    logic [RW-1:0]          commit_row;
    logic [GRID_COLS*8-1:0] commit_data;

    assign wr.wr_ready = VSYNC_WRITE ? ~pend_valid : 1'b1;
    assign xfer        = wr.wr_valid & wr.wr_ready;

    always_comb begin
        if (VSYNC_WRITE) begin
            commit_en   = pend_valid & in_vblank;
            commit_row  = pend_row;
            commit_data = pend_data;
        end else begin
            commit_en   = xfer;
            commit_row  = wr.wr_row;
            commit_data = wr.wr_data;
        end
    end

    // The pending buffer only loads while empty (wr_ready high), so it is never overwritten.
    // A write to a row that does not exist still handshakes, but it is discarded at commit.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_row   <= '0;
            pend_data  <= '0;
            for (int r = 0; r < GRID_ROWS; r++)
                for (int c = 0; c < GRID_COLS; c++)
                    tiles[r][c] <= 8'h00;
        end else begin
            if (VSYNC_WRITE) begin
                if (commit_en) begin
                    pend_valid <= 1'b0;
                end else if (xfer) begin
                    pend_valid <= 1'b1;
                    pend_row   <= wr.wr_row;
                    pend_data  <= wr.wr_data;
                end
            end
            if (commit_en && (int'(commit_row) < GRID_ROWS)) begin
                for (int c = 0; c < GRID_COLS; c++)
                    tiles[commit_row][c] <= commit_data[8*c +: 8];
            end
        end
    end

    // ---------------- two-stage pixel pipeline ----------------
    logic          hit_n;
    logic [CW-1:0] col_n;
    logic [RW-1:0] row_n;
    logic          hs_n;
    logic          vs_n;
    logic          p1_hit;
    logic [CW-1:0] p1_col;
    logic [RW-1:0] p1_row;
    logic          p1_hs;
    logic          p1_vs;
    logic [7:0]    tile_rd;

    // Off-grid pixels force the tile index to 0, so the array read stays in range.
    always_comb begin
        hit_n = (int'(x) < H_ACTIVE) && (int'(y) < V_ACTIVE) &&
                (int'(x) < GRID_COLS * TILE_W) && (int'(y) < GRID_ROWS * TILE_H);
        col_n = hit_n ? CW'(int'(x) / TILE_W) : '0;
        row_n = hit_n ? RW'(int'(y) / TILE_H) : '0;
        hs_n  = !((int'(x) >= H_ACTIVE + H_FP) && (int'(x) < H_ACTIVE + H_FP + H_SYNC));
        vs_n  = !((int'(y) >= V_ACTIVE + V_FP) && (int'(y) < V_ACTIVE + V_FP + V_SYNC));
    end

    // The stage-2 read sees the tile value from before a commit on the same edge.
    // So a colliding commit becomes visible from the next pixel tick.
    assign tile_rd = tiles[p1_row][p1_col];

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            p1_hit     <= 1'b0;
            p1_col     <= '0;
            p1_row     <= '0;
            p1_hs      <= 1'b1;
            p1_vs      <= 1'b1;
            vga_h_sync <= 1'b1;
            vga_v_sync <= 1'b1;
            vga_r      <= '0;
            vga_g      <= '0;
            vga_b      <= '0;
        end else if (pe) begin
            p1_hit     <= hit_n;
            p1_col     <= col_n;
            p1_row     <= row_n;
            p1_hs      <= hs_n;
            p1_vs      <= vs_n;
            vga_h_sync <= p1_hs;
            vga_v_sync <= p1_vs;
            vga_r      <= p1_hit ? tile_rd[7:5] : 3'd0;
            vga_g      <= p1_hit ? tile_rd[4:2] : 3'd0;
            vga_b      <= p1_hit ? tile_rd[1:0] : 2'd0;
        end
    end
endmodule

// File: tb/tb_vga_tile_renderer.sv
module tb_vga_tile_renderer;
    localparam int DIVL = 1;
    localparam int GC = 3, GR = 3, TW = 10, TH = 6;
    localparam int HA = 40, HF = 4, HS = 6, HB = 6;
    localparam int VA = 24, VF = 2, VS = 2, VB = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int RW = 2;
    localparam int DW8 = GC * 8;
    localparam int FRAME_CLKS = HT * VT * (1 << DIVL);

    logic board_clk = 1'b0;
    logic reset = 1'b1;
    always #5 board_clk = ~board_clk;

    logic           bvalid;
    logic [RW-1:0]  brow;
    logic [DW8-1:0] bdata;

    vga_tile_renderer_if #(.GRID_COLS(GC), .RW(RW)) w0 ();
    vga_tile_renderer_if #(.GRID_COLS(GC), .RW(RW)) w1 ();
    assign w0.wr_valid = bvalid;
    assign w0.wr_row   = brow;
    assign w0.wr_data  = bdata;
    assign w1.wr_valid = bvalid;
    assign w1.wr_row   = brow;
    assign w1.wr_data  = bdata;

    logic hs0, vs0, vb0, fs0, hs1, vs1, vb1, fs1;
    logic [2:0] r0, g0, r1, g1;
    logic [1:0] b0, b1;

    vga_tile_renderer #(
        .CLK_DIV_LOG2(DIVL), .GRID_COLS(GC), .GRID_ROWS(GR), .TILE_W(TW), .TILE_H(TH),
        .VSYNC_WRITE(1'b0), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut0 (
        .board_clk(board_clk), .reset(reset), .wr(w0.slave),
        .vga_h_sync(hs0), .vga_v_sync(vs0), .vga_r(r0), .vga_g(g0), .vga_b(b0),
        .in_vblank(vb0), .frame_start(fs0)
    );

    vga_tile_renderer #(
        .CLK_DIV_LOG2(DIVL), .GRID_COLS(GC), .GRID_ROWS(GR), .TILE_W(TW), .TILE_H(TH),
        .VSYNC_WRITE(1'b1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut1 (
        .board_clk(board_clk), .reset(reset), .wr(w1.slave),
        .vga_h_sync(hs1), .vga_v_sync(vs1), .vga_r(r1), .vga_g(g1), .vga_b(b1),
        .in_vblank(vb1), .frame_start(fs1)
    );

    // Expected DUT outputs after one clock edge. pix = {hsync, vsync, rgb332}.
    typedef struct packed {
        logic [9:0] pix0;
        logic [9:0] pix1;
        logic       vb;
        logic       fs;
        logic       rdy1;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model.
    // Raster position is derived from the count of pixel ticks since reset.
    // Tile contents are kept as plain arrays.
    int             k;
    logic [7:0]     mt0 [GR][GC];
    logic [7:0]     mt1 [GR][GC];
    logic           pend;
    logic [RW-1:0]  prow;
    logic [DW8-1:0] pdata;
    logic [9:0]     last0, last1;

    function automatic logic [9:0] pix_of(int p, bit use1);
        int px, py;
        logic hs, vs;
        logic [7:0] c;
        if (p < 0) return 10'h300;
        px = p % HT;
        py = (p / HT) % VT;
        hs = !(px >= HA + HF && px < HA + HF + HS);
        vs = !(py >= VA + VF && py < VA + VF + VS);
        c  = 8'h00;
        if (px < HA && py < VA && px < GC * TW && py < GR * TH)
            c = use1 ? mt1[py / TH][px / TW] : mt0[py / TH][px / TW];
        return {hs, vs, c};
    endfunction

    always @(posedge board_clk) begin
        exp_t e;
        if (reset) begin
            k = 0;
            pend = 1'b0;
            prow = '0;
            pdata = '0;
            for (int r = 0; r < GR; r++)
                for (int c = 0; c < GC; c++) begin
                    mt0[r][c] = 8'h00;
                    mt1[r][c] = 8'h00;
                end
            last0 = 10'h300;
            last1 = 10'h300;
            e.pix0 = last0; e.pix1 = last1; e.vb = 1'b0; e.fs = 1'b0; e.rdy1 = 1'b1;
            q.push_back(e);
        end else begin
            int  m_pre, m_post;
            bit  tick, vb_pre, rdy1_pre;
            k++;
            m_pre    = (k - 1) / 2;
            m_post   = k / 2;
            tick     = (k % 2) == 0;
            vb_pre   = ((m_pre / HT) % VT) >= VA;
            rdy1_pre = !pend;
            // The pixel leaving the pipeline on this tick was addressed two ticks ago.
            // It reads tile contents from before this edge's write.
            if (tick) begin
                last0 = pix_of(m_post - 2, 1'b0);
                last1 = pix_of(m_post - 2, 1'b1);
            end
            if (bvalid && int'(brow) < GR)
                for (int c = 0; c < GC; c++) mt0[brow][c] = bdata[8*c +: 8];
            if (pend && vb_pre) begin
                if (int'(prow) < GR)
                    for (int c = 0; c < GC; c++) mt1[prow][c] = pdata[8*c +: 8];
                pend = 1'b0;
            end else if (bvalid && rdy1_pre) begin
                pend  = 1'b1;
                prow  = brow;
                pdata = bdata;
            end
            e.pix0 = last0;
            e.pix1 = last1;
            e.vb   = ((m_post / HT) % VT) >= VA;
            e.fs   = tick && (((m_post - 1) % (HT * VT)) == 0);
            e.rdy1 = !pend;
            q.push_back(e);
        end
    end

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h time=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares the DUT against the oldest pending expectation.
    always @(negedge board_clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("pix0", {hs0, vs0, r0, g0, b0}, e.pix0);
            check("pix1", {hs1, vs1, r1, g1, b1}, e.pix1);
            check("vblank0", 10'(vb0), 10'(e.vb));
            check("vblank1", 10'(vb1), 10'(e.vb));
            check("frame_start0", 10'(fs0), 10'(e.fs));
            check("frame_start1", 10'(fs1), 10'(e.fs));
            check("ready0", 10'(w0.wr_ready), 10'(1'b1));
            check("ready1", 10'(w1.wr_ready), 10'(e.rdy1));
        end
    end

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge board_clk);
            if ($urandom_range(0, 31) == 0) bvalid = ~bvalid;
            brow  = RW'($urandom_range(0, 3));
            bdata = DW8'($urandom);
        end
    endtask

    initial begin
        bvalid = 1'b0;
        brow   = '0;
        bdata  = '0;
        reset  = 1'b1;
        repeat (3) @(negedge board_clk);
        reset = 1'b0;

        // Write row 0 during active video. While the buffered DUT waits for vblank,
        // hold a second request high; it must not be accepted.
        repeat (40) @(negedge board_clk);
        bvalid = 1'b1;
        brow   = 2'd0;
        bdata  = {GC{8'hE0}};
        @(negedge board_clk);
        brow   = 2'd1;
        bdata  = {GC{8'h1C}};
        repeat (200) @(negedge board_clk);
        bvalid = 1'b0;
        repeat (FRAME_CLKS) @(negedge board_clk);

        // A write to a row that does not exist.
        bvalid = 1'b1;
        brow   = 2'd3;
        bdata  = {GC{8'hFF}};
        @(negedge board_clk);
        bvalid = 1'b0;
        repeat (FRAME_CLKS) @(negedge board_clk);

        random_cycles(3 * FRAME_CLKS);

        // Reset mid-frame with a buffered write outstanding.
        bvalid = 1'b0;
        repeat (HT * 2 * 5) @(negedge board_clk);
        bvalid = 1'b1;
        brow   = 2'd2;
        bdata  = {GC{8'h03}};
        @(negedge board_clk);
        bvalid = 1'b0;
        repeat (7) @(negedge board_clk);
        reset = 1'b1;
        repeat (3) @(negedge board_clk);
        reset = 1'b0;

        random_cycles(FRAME_CLKS + FRAME_CLKS / 2);
        bvalid = 1'b0;
        repeat (4) @(negedge board_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
